countdown_alarm_ctrl: RTL and testbench
=======================================

# countdown_alarm_ctrl

BCD countdown timer (HH:MM:SS) that drives the set/clear inputs of the alarm-latch stage. It counts down on a 1 Hz strobe and asserts a single-cycle set pulse when the count reaches 00:00:00. A user acknowledge produces a single-cycle active-low clear pulse. Both alarm outputs are glitch-free registered signals, because the latch downstream is edge-sensitive: it sets on a rising `alarm_set` and clears on a falling `alarm_clr_n`.

## Interface
Parameters:
- `HOUR_MAX`, default 8'h23: largest loadable BCD hour value.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle strobe, once per second.
- `load`  in  1  load `ld_hh`/`ld_mm`/`ld_ss` into the counter.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting.
- `ack`  in  1  user acknowledge of an expired alarm.
- `ld_hh`, `ld_mm`, `ld_ss`  in  8 each  BCD load values.
- `hh`, `mm`, `ss`  out  8 each  current BCD count.
- `running`  out  1  high while the FSM is in RUN.
- `alarm_set`  out  1  one-cycle high pulse on expiry.
- `alarm_clr_n`  out  1  one-cycle low pulse on acknowledge; idles high.

## Operation
FSM states: IDLE, RUN, PAUSE, EXPIRED.

- **IDLE**
  - `load` with a valid value copies the load inputs into the counter.
  - Valid means: every nibble is at most 9, `ss` and `mm` are at most 8'h59, and `hh` is at most `HOUR_MAX`. An invalid load is ignored and the count is unchanged.
  - `start` with a nonzero count moves to RUN. `start` with a zero count is ignored.
- **RUN**
  - Each `tick_1hz` decrements `ss`.
  - `ss` borrows from 00 to 59 and decrements `mm`. `mm` borrows from 00 to 59 and decrements `hh`.
  - A tick that produces 00:00:00 moves to EXPIRED and asserts `alarm_set`.
  - `stop` moves to PAUSE.
  - `load` is ignored in RUN.
- **PAUSE**
  - Count is held.
  - `load` behaves as in IDLE.
  - `start` with a nonzero count returns to RUN.
  - `ack` moves to IDLE with the count unchanged and no clear pulse.
- **EXPIRED**
  - Count is held at 00:00:00. Ticks, `load`, `start` and `stop` are ignored.
  - `ack` pulses `alarm_clr_n` low and moves to IDLE.
- Priority when inputs coincide: `reset` > `ack` > `stop` > `start` > `load` > `tick_1hz`.
  - Example: `stop` and `tick_1hz` in the same cycle in RUN gives PAUSE with no decrement.
  - Example: `start` and `load` in the same cycle in IDLE: start is evaluated against the old count and the load is dropped.
- Reset:
  - Reset values: state IDLE, `hh`/`mm`/`ss` = 8'h00, `running` = 0, `alarm_set` = 0, `alarm_clr_n` = 1.
  - Reset in any state, including mid-count or EXPIRED, goes directly to these values.
  - Reset never produces a rising `alarm_set` or a falling `alarm_clr_n`.

## Timing
- All outputs are registered.
- A control input sampled at edge n takes effect on the outputs after edge n.
- Decrement latency: the tick at edge n updates the count after edge n, i.e. one cycle.
- `alarm_set` is high for exactly the one cycle in which the count first reads 00:00:00. It is low in every other cycle.
- `ack` in EXPIRED sampled at edge n: `alarm_clr_n` is 0 for the single cycle after edge n and 1 otherwise.
- `running` changes in the same cycle as the state register.
- A held `tick_1hz` (more than one cycle high) decrements once per cycle. Callers must supply a single-cycle strobe.

## Structure
- Shared package `alarm_pkg` holds:
  - the state encoding (2-bit enum: IDLE, RUN, PAUSE, EXPIRED);
  - constants `BCD_59` = 8'h59 and `BCD_ZERO` = 8'h00.
- One sub-module, `bcd_pair_down`:
  - an 8-bit BCD down counter with a modulo-limit input, decrement enable, load, and a `borrow` output;
  - instantiated three times (ss, mm, hh), chained through `borrow`.
- The FSM and the alarm pulse registers live in the top module.

## Test plan
- Load 00:00:03, `start`, three ticks → `ss` reads 02, 01, 00; `alarm_set` high for exactly 1 cycle after the third tick; state EXPIRED; `running` = 0.
- Load 01:00:00, `start`, one tick → count 00:59:59 (double borrow); no `alarm_set`.
- RUN at 00:00:10, `stop` and `tick_1hz` in the same cycle → PAUSE, count stays 00:00:10; `start` then one tick → 00:00:09.
- EXPIRED, `ack` → `alarm_clr_n` low for 1 cycle, state IDLE. A further `ack` produces no pulse. Ticks in EXPIRED leave the count at 00:00:00.
- Load ss = 8'h5A, then load hh = 8'h24 with `HOUR_MAX` = 8'h23 → both loads ignored, count unchanged. `start` at 00:00:00 → stays IDLE.
- `reset` in RUN at 00:00:01, coincident with a tick → next cycle shows 00:00:00, IDLE, `alarm_set` = 0, `alarm_clr_n` = 1, with no alarm pulse.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding, BCD constants and the load-value validity check
// for the countdown alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] BCD_59   = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max_value);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_value);
  endfunction

endpackage

// File: rtl/bcd_pair_down.sv
// Two-digit BCD down counter: wraps from 00 to limit_i and flags a borrow
// to the next stage in the cycle it wraps.
module bcd_pair_down
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] limit_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o,
  output logic       borrow_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      if (cnt_q == BCD_ZERO) begin
        cnt_d = limit_i;
      end else if (cnt_q[3:0] == 4'h0) begin
        cnt_d = {cnt_q[7:4] - 4'h1, 4'h9};
      end else begin
        cnt_d = {cnt_q[7:4], cnt_q[3:0] - 4'h1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= BCD_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign borrow_o = dec_i && (cnt_q == BCD_ZERO);

endmodule

// File: rtl/countdown_alarm_ctrl.sv
// HH:MM:SS BCD countdown with registered single-cycle alarm set pulse and
// active-low clear pulse for an edge-sensitive downstream latch.
module countdown_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       alarm_set,
  output logic       alarm_clr_n
);

  state_e state_q, state_d;
  logic   running_q, alarm_set_q, alarm_clr_n_q;
  logic   load_en, dec, expire, clear;
  logic   ss_borrow, mm_borrow, hh_borrow;
  logic   count_zero, one_left, load_ok;

  assign count_zero = (hh == BCD_ZERO) && (mm == BCD_ZERO) && (ss == BCD_ZERO);
  assign one_left   = (hh == BCD_ZERO) && (mm == BCD_ZERO) && (ss == 8'h01);
  assign load_ok    = bcd_valid(ld_ss, BCD_59) && bcd_valid(ld_mm, BCD_59) &&
                      bcd_valid(ld_hh, HOUR_MAX);
  // stop outranks the tick, so a coincident stop suppresses the decrement.
  assign dec        = (state_q == ST_RUN) && !stop && tick_1hz;

  bcd_pair_down u_ss (
    .clk(clk), .reset(reset), .limit_i(BCD_59), .dec_i(dec),
    .load_i(load_en), .load_val_i(ld_ss), .cnt_o(ss), .borrow_o(ss_borrow)
  );

  bcd_pair_down u_mm (
    .clk(clk), .reset(reset), .limit_i(BCD_59), .dec_i(ss_borrow),
    .load_i(load_en), .load_val_i(ld_mm), .cnt_o(mm), .borrow_o(mm_borrow)
  );

  bcd_pair_down u_hh (
    .clk(clk), .reset(reset), .limit_i(HOUR_MAX), .dec_i(mm_borrow),
    .load_i(load_en), .load_val_i(ld_hh), .cnt_o(hh), .borrow_o(hh_borrow)
  );

  // FSM next state; inputs resolved in order ack > stop > start > load > tick.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    expire  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = state_q;
        end else if (start) begin
          if (!count_zero) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end else if (load && load_ok) begin
          load_en = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (dec && (one_left || hh_borrow)) begin
          // hh_borrow can only mean an underflow; treat it as expiry.
          state_d = ST_EXPIRED;
          expire  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (ack) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else begin
          state_d = ST_EXPIRED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered alarm/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      running_q     <= 1'b0;
      alarm_set_q   <= 1'b0;
      alarm_clr_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      running_q     <= (state_d == ST_RUN);
      alarm_set_q   <= expire;
      alarm_clr_n_q <= ~clear;
    end
  end

  assign running     = running_q;
  assign alarm_set   = alarm_set_q;
  assign alarm_clr_n = alarm_clr_n_q;

endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// Directed-vector bench: the stimulus pushes hand-computed expectations into
// a queue and a negedge monitor pops and compares them against the DUT.
module tb_countdown_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, load, start, stop, ack;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic [7:0] hh, mm, ss;
  logic       running, alarm_set, alarm_clr_n;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_q[$];
  string       name_q[$];

  countdown_alarm_ctrl #(.HOUR_MAX(8'h23)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load), .start(start),
    .stop(stop), .ack(ack), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .hh(hh), .mm(mm), .ss(ss), .running(running), .alarm_set(alarm_set),
    .alarm_clr_n(alarm_clr_n)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] ex(input logic [23:0] cnt, input logic run,
                                     input logic set, input logic clrn);
    return {cnt, run, set, clrn};
  endfunction

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input logic r, input logic t, input logic l, input logic st,
                      input logic sp, input logic a, input logic [23:0] ld,
                      input logic [26:0] e, input string n);
    reset = r; tick_1hz = t; load = l; start = st; stop = sp; ack = a;
    ld_hh = ld[23:16]; ld_mm = ld[15:8]; ld_ss = ld[7:0];
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    reset = 1'b0; tick_1hz = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  // Monitor: compare every presented output word against the queue head.
  always @(negedge clk) begin
    logic [26:0] act, e;
    string       n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {hh, mm, ss, running, alarm_set, alarm_clr_n};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got hhmmss=%h run=%b set=%b clrn=%b, expected hhmmss=%h run=%b set=%b clrn=%b",
                 n, act[26:3], act[2], act[1], act[0], e[26:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; tick_1hz = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00;
    //    rst tck ld  st  sp  ack  load value   expected after edge
    step(1, 0, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "reset");
    step(0, 0, 1, 0, 0, 0, 24'h000003, ex(24'h000003, 0, 0, 1), "load_3s");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h000003, 1, 0, 1), "start_3s");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000002, 1, 0, 1), "tick_02");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000001, 1, 0, 1), "tick_01");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 1, 1), "expire_set");
    step(0, 0, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "set_one_cycle");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "tick_in_expired");
    step(0, 0, 1, 1, 0, 0, 24'h000105, ex(24'h000000, 0, 0, 1), "start_load_in_expired");
    step(0, 0, 0, 0, 0, 1, 24'h000000, ex(24'h000000, 0, 0, 0), "ack_clear_pulse");
    step(0, 0, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "clear_one_cycle");
    step(0, 0, 0, 0, 0, 1, 24'h000000, ex(24'h000000, 0, 0, 1), "ack_idle_no_pulse");
    step(0, 0, 1, 0, 0, 0, 24'h010000, ex(24'h010000, 0, 0, 1), "load_1h");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h010000, 1, 0, 1), "start_1h");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h005959, 1, 0, 1), "double_borrow");
    step(0, 0, 0, 0, 1, 0, 24'h000000, ex(24'h005959, 0, 0, 1), "stop_pause");
    step(0, 0, 0, 0, 0, 1, 24'h000000, ex(24'h005959, 0, 0, 1), "ack_in_pause");
    step(0, 0, 1, 0, 0, 0, 24'h000010, ex(24'h000010, 0, 0, 1), "load_10s");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h000010, 1, 0, 1), "start_10s");
    step(0, 1, 0, 0, 1, 0, 24'h000000, ex(24'h000010, 0, 0, 1), "stop_beats_tick");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h000010, 1, 0, 1), "resume");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000009, 1, 0, 1), "tick_nibble_borrow");
    step(0, 0, 0, 0, 1, 0, 24'h000000, ex(24'h000009, 0, 0, 1), "stop_again");
    step(0, 0, 0, 0, 0, 1, 24'h000000, ex(24'h000009, 0, 0, 1), "ack_to_idle");
    step(0, 0, 1, 0, 0, 0, 24'h00005A, ex(24'h000009, 0, 0, 1), "load_bad_ss");
    step(0, 0, 1, 0, 0, 0, 24'h240000, ex(24'h000009, 0, 0, 1), "load_bad_hh");
    step(0, 0, 1, 0, 0, 0, 24'h000A00, ex(24'h000009, 0, 0, 1), "load_bad_mm_nibble");
    step(0, 0, 1, 0, 0, 0, 24'h006000, ex(24'h000009, 0, 0, 1), "load_mm_60");
    step(0, 0, 1, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "load_zero");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "start_at_zero");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "tick_in_idle");
    step(0, 0, 1, 0, 0, 0, 24'h235959, ex(24'h235959, 0, 0, 1), "load_max");
    step(0, 0, 1, 1, 0, 0, 24'h000005, ex(24'h235959, 1, 0, 1), "start_drops_load");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h235958, 1, 0, 1), "tick_from_max");
    step(0, 0, 1, 0, 0, 0, 24'h000005, ex(24'h235958, 1, 0, 1), "load_ignored_in_run");
    step(0, 0, 0, 0, 1, 0, 24'h000000, ex(24'h235958, 0, 0, 1), "stop_max");
    step(0, 0, 1, 0, 0, 0, 24'h000001, ex(24'h000001, 0, 0, 1), "load_in_pause");
    step(0, 0, 0, 1, 0, 0, 24'h000000, ex(24'h000001, 1, 0, 1), "start_1s");
    step(1, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "reset_with_tick");
    step(0, 0, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "after_reset_quiet");
    step(0, 1, 0, 0, 0, 0, 24'h000000, ex(24'h000000, 0, 0, 1), "after_reset_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
